// File: rtl/sdram_port_arbiter.sv
// Two-master round-robin arbiter in front of the SDRAM controller Avalon-MM slave.
// A read-tag FIFO steers each pipelined readdatavalid back to the master that issued the read.
module sdram_port_arbiter #(
    parameter int unsigned ADDR_W        = 22,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned BURST_LEN     = 8,
    parameter int unsigned PENDING_DEPTH = 4
) (
    input  logic                            clk_clk,
    input  logic                            reset_reset,

    input  logic [ADDR_W-1:0]               m0_address,
    input  logic [DATA_W/8-1:0]             m0_byteenable_n,
    input  logic                            m0_read_n,
    input  logic                            m0_write_n,
    input  logic [DATA_W-1:0]               m0_writedata,
    output logic [DATA_W-1:0]               m0_readdata,
    output logic                            m0_readdatavalid,
    output logic                            m0_waitrequest,

    input  logic [ADDR_W-1:0]               m1_address,
    input  logic [DATA_W/8-1:0]             m1_byteenable_n,
    input  logic                            m1_read_n,
    input  logic                            m1_write_n,
    input  logic [DATA_W-1:0]               m1_writedata,
    output logic [DATA_W-1:0]               m1_readdata,
    output logic                            m1_readdatavalid,
    output logic                            m1_waitrequest,

    output logic [ADDR_W-1:0]               sdram_control_address,
    output logic [DATA_W/8-1:0]             sdram_control_byteenable_n,
    output logic                            sdram_control_chipselect,
    output logic [DATA_W-1:0]               sdram_control_writedata,
    output logic                            sdram_control_read_n,
    output logic                            sdram_control_write_n,
    input  logic [DATA_W-1:0]               sdram_control_readdata,
    input  logic                            sdram_control_readdatavalid,
    input  logic                            sdram_control_waitrequest,

    output logic [$clog2(PENDING_DEPTH):0]  pending_count,
    output logic                            err_orphan
);

    localparam int unsigned PTR_W  = $clog2(PENDING_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BCNT_W = 8;
    localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(PENDING_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     last_gnt_q, last_gnt_d;
    logic [BCNT_W-1:0]        burst_cnt_q, burst_cnt_d;
    logic [PENDING_DEPTH-1:0] tag_q, tag_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     err_q, err_d;

    logic req0, req1, granted, sel, sel_read, sel_write, req_sel, req_oth;
    logic blk, cs, accept, push, pop, empty, head;

    assign req0      = ~m0_read_n | ~m0_write_n;
    assign req1      = ~m1_read_n | ~m1_write_n;
    assign granted   = (state_q != IDLE);
    assign sel       = (state_q == GNT1);
    // Read wins when a master asserts both strobes.
    assign sel_read  = granted & ~(sel ? m1_read_n : m0_read_n);
    assign sel_write = granted & ~sel_read & ~(sel ? m1_write_n : m0_write_n);
    assign req_sel   = sel_read | sel_write;
    assign req_oth   = sel ? req0 : req1;
    assign blk       = sel_read & (count_q == CNT_FULL);
    assign cs        = req_sel & ~blk;
    assign accept    = cs & ~sdram_control_waitrequest;

    assign sdram_control_address      = sel ? m1_address      : m0_address;
    assign sdram_control_byteenable_n = sel ? m1_byteenable_n : m0_byteenable_n;
    assign sdram_control_writedata    = sel ? m1_writedata    : m0_writedata;
    assign sdram_control_chipselect   = cs;
    assign sdram_control_read_n       = ~(cs & sel_read);
    assign sdram_control_write_n      = ~(cs & sel_write);

    assign m0_waitrequest = (state_q == GNT0) ? (sdram_control_waitrequest | blk | ~req_sel) : 1'b1;
    assign m1_waitrequest = (state_q == GNT1) ? (sdram_control_waitrequest | blk | ~req_sel) : 1'b1;

    assign empty            = (count_q == CNT_W'(0));
    assign head             = tag_q[rd_ptr_q];
    assign push             = accept & sel_read;
    assign pop              = sdram_control_readdatavalid & ~empty;
    assign m0_readdatavalid = pop & ~head;
    assign m1_readdatavalid = pop & head;
    assign m0_readdata      = sdram_control_readdata;
    assign m1_readdata      = sdram_control_readdata;
    assign pending_count    = count_q;
    assign err_orphan       = err_q;

    // Grant FSM: round-robin on contention, hand over after BURST_LEN accepts if the other waits.
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                burst_cnt_d = '0;
                if (req0 && (!req1 || last_gnt_q)) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!req_sel) begin
                    last_gnt_d  = sel;
                    burst_cnt_d = '0;
                    state_d     = req_oth ? (sel ? GNT0 : GNT1) : IDLE;
                end else if (accept) begin
                    if (burst_cnt_q == BURST_LAST) begin
                        // Counter saturates so a late requester still gets the next hand-over.
                        if (req_oth) begin
                            last_gnt_d  = sel;
                            burst_cnt_d = '0;
                            state_d     = sel ? GNT0 : GNT1;
                        end
                    end else begin
                        burst_cnt_d = burst_cnt_q + BCNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read-tag FIFO: one bit per outstanding read naming its master.
    always_comb begin
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q | (sdram_control_readdatavalid & empty);
        if (push) begin
            tag_d[wr_ptr_q] = sel;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;
            burst_cnt_q <= '0;
            tag_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
            tag_q       <= tag_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level model of arbitration and read routing.
module tb_sdram_port_arbiter;

    localparam int AW = 22;
    localparam int DW = 16;
    localparam int BW = 2;
    localparam int BL = 8;
    localparam int PD = 4;
    localparam int PW = $clog2(PD) + 1;

    typedef struct {
        bit            rd;
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [BW-1:0] be;
        int            start;
    } txn_t;
    typedef struct { int due; logic [DW-1:0] d; } ret_t;
    typedef struct { int m; logic [AW-1:0] a; logic [DW-1:0] d; int cyc; } acc_t;
    typedef struct { int m; logic [DW-1:0] d; } val_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] m_addr [2];
    logic [BW-1:0] m_be   [2];
    logic          m_rdn  [2];
    logic          m_wrn  [2];
    logic [DW-1:0] m_wd   [2];
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_rdv, m1_rdv, m0_wait, m1_wait;
    logic [AW-1:0] sd_addr;
    logic [BW-1:0] sd_be;
    logic          sd_cs, sd_rdn, sd_wrn;
    logic [DW-1:0] sd_wd, sd_rdata;
    logic          sd_rdv, sd_wait;
    logic [PW-1:0] pend;
    logic          err;

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .PENDING_DEPTH(PD)) dut (
        .clk_clk                    (clk),
        .reset_reset                (rst),
        .m0_address                 (m_addr[0]),
        .m0_byteenable_n            (m_be[0]),
        .m0_read_n                  (m_rdn[0]),
        .m0_write_n                 (m_wrn[0]),
        .m0_writedata               (m_wd[0]),
        .m0_readdata                (m0_rdata),
        .m0_readdatavalid           (m0_rdv),
        .m0_waitrequest             (m0_wait),
        .m1_address                 (m_addr[1]),
        .m1_byteenable_n            (m_be[1]),
        .m1_read_n                  (m_rdn[1]),
        .m1_write_n                 (m_wrn[1]),
        .m1_writedata               (m_wd[1]),
        .m1_readdata                (m1_rdata),
        .m1_readdatavalid           (m1_rdv),
        .m1_waitrequest             (m1_wait),
        .sdram_control_address      (sd_addr),
        .sdram_control_byteenable_n (sd_be),
        .sdram_control_chipselect   (sd_cs),
        .sdram_control_writedata    (sd_wd),
        .sdram_control_read_n       (sd_rdn),
        .sdram_control_write_n      (sd_wrn),
        .sdram_control_readdata     (sd_rdata),
        .sdram_control_readdatavalid(sd_rdv),
        .sdram_control_waitrequest  (sd_wait),
        .pending_count              (pend),
        .err_orphan                 (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: current owner (-1 none), last owner, accepts in this grant, read tags.
    int  own = -1;
    int  last = 1;
    int  run = 0;
    int  tags[$];
    bit  orphan = 1'b0;

    txn_t mq0[$], mq1[$];
    txn_t cur [2];
    bit   cur_v [2];

    ret_t retq[$];
    int   last_due = 0;
    int   ret_mode = 1;     // 0 random latency, 1 fixed latency 3, 2 no automatic returns
    bit   force_rdv = 1'b0;
    bit   force_wait = 1'b0;
    bit   rand_wait = 1'b0;

    acc_t          alog[$];
    val_t          vlog[$];
    logic [DW-1:0] sent[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        own = -1; last = 1; run = 0; orphan = 1'b0;
        tags.delete(); retq.delete(); mq0.delete(); mq1.delete();
        cur_v[0] = 1'b0; cur_v[1] = 1'b0;
        force_rdv = 1'b0; last_due = cyc;
    endtask

    task automatic enq(input int m, input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be, input int start);
        txn_t t;
        t.rd = rd; t.wr = wr; t.a = a; t.d = d; t.be = be; t.start = start;
        if (m == 0) mq0.push_back(t);
        else        mq1.push_back(t);
    endtask

    task automatic drive_inputs();
        if (!cur_v[0] && mq0.size() > 0 && mq0[0].start <= cyc) begin
            cur[0] = mq0.pop_front(); cur_v[0] = 1'b1;
        end
        if (!cur_v[1] && mq1.size() > 0 && mq1[0].start <= cyc) begin
            cur[1] = mq1.pop_front(); cur_v[1] = 1'b1;
        end
        for (int m = 0; m < 2; m++) begin
            if (cur_v[m]) begin
                m_rdn[m] = !cur[m].rd; m_wrn[m] = !cur[m].wr;
                m_addr[m] = cur[m].a; m_wd[m] = cur[m].d; m_be[m] = cur[m].be;
            end else begin
                m_rdn[m] = 1'b1; m_wrn[m] = 1'b1;
                m_addr[m] = AW'($urandom); m_wd[m] = DW'($urandom); m_be[m] = BW'($urandom);
            end
        end
        sd_wait  = force_wait ? 1'b1 : (rand_wait ? ($urandom_range(0, 3) == 0) : 1'b0);
        sd_rdata = DW'($urandom);
        sd_rdv   = 1'b0;
        if (retq.size() > 0 && retq[0].due <= cyc) begin
            ret_t r;
            r = retq.pop_front();
            sd_rdv = 1'b1; sd_rdata = r.d;
            sent.push_back(r.d);
        end else if (force_rdv) begin
            sd_rdv = 1'b1;
        end
    endtask

    task automatic eval_and_check();
        bit r [2];
        bit e_wait [2];
        bit e_v [2];
        bit rdop, blocked, e_cs, e_rdn, e_wrn, acc;
        r[0] = !m_rdn[0] || !m_wrn[0];
        r[1] = !m_rdn[1] || !m_wrn[1];
        e_wait[0] = 1'b1; e_wait[1] = 1'b1; e_v[0] = 1'b0; e_v[1] = 1'b0;
        rdop = 1'b0; blocked = 1'b0; e_cs = 1'b0; e_rdn = 1'b1; e_wrn = 1'b1; acc = 1'b0;
        if (!rst && own >= 0) begin
            rdop        = !m_rdn[own];
            blocked     = rdop && (tags.size() == PD);
            e_cs        = r[own] && !blocked;
            e_wait[own] = sd_wait || blocked || !r[own];
            e_rdn       = !(e_cs && rdop);
            e_wrn       = !(e_cs && !rdop);
            acc         = e_cs && !sd_wait;
        end
        if (!rst && sd_rdv && tags.size() > 0) e_v[tags[0]] = 1'b1;

        check_eq("m0_waitrequest", 32'(m0_wait), 32'(e_wait[0]));
        check_eq("m1_waitrequest", 32'(m1_wait), 32'(e_wait[1]));
        check_eq("chipselect", 32'(sd_cs), 32'(e_cs));
        check_eq("sdram_read_n", 32'(sd_rdn), 32'(e_rdn));
        check_eq("sdram_write_n", 32'(sd_wrn), 32'(e_wrn));
        check_eq("pending_count", 32'(pend), 32'(tags.size()));
        check_eq("err_orphan", 32'(err), 32'(orphan));
        check_eq("m0_readdatavalid", 32'(m0_rdv), 32'(e_v[0]));
        check_eq("m1_readdatavalid", 32'(m1_rdv), 32'(e_v[1]));
        if (e_cs) begin
            check_eq("sdram_address", 32'(sd_addr), 32'(m_addr[own]));
            check_eq("sdram_writedata", 32'(sd_wd), 32'(m_wd[own]));
            check_eq("sdram_byteenable_n", 32'(sd_be), 32'(m_be[own]));
        end
        if (e_v[0]) check_eq("m0_readdata", 32'(m0_rdata), 32'(sd_rdata));
        if (e_v[1]) check_eq("m1_readdata", 32'(m1_rdata), 32'(sd_rdata));

        // Log what the DUT actually did, for scenario-level checks.
        if (sd_cs && !sd_wait) begin
            acc_t o;
            o.m = !m0_wait ? 0 : (!m1_wait ? 1 : 2);
            o.a = sd_addr; o.d = sd_wd; o.cyc = cyc;
            alog.push_back(o);
        end
        if (m0_rdv) begin val_t v; v.m = 0; v.d = m0_rdata; vlog.push_back(v); end
        if (m1_rdv) begin val_t v; v.m = 1; v.d = m1_rdata; vlog.push_back(v); end

        if (!rst) begin
            if (sd_rdv) begin
                if (tags.size() > 0) void'(tags.pop_front());
                else                 orphan = 1'b1;
            end
            if (acc && rdop) begin
                tags.push_back(own);
                if (ret_mode != 2) begin
                    ret_t rr;
                    int   due;
                    due = cyc + ((ret_mode == 1) ? 3 : int'($urandom_range(1, 4)));
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    rr.due = due; rr.d = DW'($urandom);
                    retq.push_back(rr);
                end
            end
            if (acc) cur_v[own] = 1'b0;
            if (own < 0) begin
                if (r[0] && r[1]) own = 1 - last;
                else if (r[0])    own = 0;
                else if (r[1])    own = 1;
                run = 0;
            end else if (!r[own]) begin
                last = own; run = 0;
                own  = r[1-own] ? 1 - own : -1;
            end else if (acc) begin
                run++;
                if (run >= BL && r[1-own]) begin
                    last = own; run = 0; own = 1 - own;
                end
            end
        end
    endtask

    task automatic step();
        drive_inputs();
        #2;
        eval_and_check();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic bit is_idle();
        return own < 0 && mq0.size() == 0 && mq1.size() == 0 && !cur_v[0] && !cur_v[1]
               && retq.size() == 0 && tags.size() == 0;
    endfunction

    task automatic run_until_idle(input string tag, input int max);
        int n = 0;
        do begin
            step(); n++;
        end while (!is_idle() && n < max);
        check_eq({tag, " reached idle"}, 32'(is_idle()), 32'd1);
    endtask

    initial begin
        int base;
        int t;
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        step(); step();
        check_eq("reset m0_waitrequest", 32'(m0_wait), 32'd1);
        check_eq("reset chipselect", 32'(sd_cs), 32'd0);
        rst = 1'b0;

        // Both masters stream writes from a fresh reset.
        alog.delete(); base = cyc;
        for (int i = 0; i < 16; i++) enq(0, 1'b0, 1'b1, AW'(32'h1000 + i), DW'(32'hB000 + i), 2'b00, base);
        for (int i = 0; i < 8; i++)  enq(1, 1'b0, 1'b1, AW'(32'h2000 + i), DW'(32'hC000 + i), 2'b00, base);
        run_until_idle("stream", 200);
        check_eq("stream accept count", 32'(alog.size()), 32'd24);
        for (int i = 0; i < 24 && i < alog.size(); i++)
            check_eq("stream owner", 32'(alog[i].m), (i >= 8 && i < 16) ? 32'd1 : 32'd0);

        // Single master, three writes.
        alog.delete(); base = cyc;
        for (int i = 0; i < 3; i++)
            enq(0, 1'b0, 1'b1, AW'(32'h100 + i), DW'(32'hA5A0 + i), (i == 1) ? 2'b01 : 2'b00, base);
        run_until_idle("write3", 50);
        check_eq("write3 accept count", 32'(alog.size()), 32'd3);
        for (int i = 0; i < 3 && i < alog.size(); i++) begin
            check_eq("write3 master", 32'(alog[i].m), 32'd0);
            check_eq("write3 address", 32'(alog[i].a), 32'h100 + 32'(i));
            check_eq("write3 data", 32'(alog[i].d), 32'hA5A0 + 32'(i));
            check_eq("write3 cycle", 32'(alog[i].cyc), 32'(base + 1 + i));
        end

        // Reads from both masters routed back in order.
        vlog.delete(); sent.delete(); ret_mode = 1; base = cyc;
        for (int i = 0; i < 3; i++) enq(1, 1'b1, 1'b0, AW'(32'h300 + i), '0, 2'b00, base);
        enq(0, 1'b1, 1'b0, AW'(32'h400), '0, 2'b00, base + 6);
        run_until_idle("read4", 100);
        check_eq("read4 valid count", 32'(vlog.size()), 32'd4);
        for (int i = 0; i < 4 && i < vlog.size() && i < sent.size(); i++) begin
            check_eq("read4 valid owner", 32'(vlog[i].m), (i < 3) ? 32'd1 : 32'd0);
            check_eq("read4 valid data", 32'(vlog[i].d), 32'(sent[i]));
        end

        // Pending-read limit.
        ret_mode = 2; alog.delete(); base = cyc;
        for (int i = 0; i < 5; i++) enq(0, 1'b1, 1'b0, AW'(32'h500 + i), '0, 2'b00, base);
        repeat (10) step();
        check_eq("full pending_count", 32'(pend), 32'd4);
        check_eq("full chipselect", 32'(sd_cs), 32'd0);
        check_eq("full m0_waitrequest", 32'(m0_wait), 32'd1);
        check_eq("full accept count", 32'(alog.size()), 32'd4);
        force_rdv = 1'b1; step(); force_rdv = 1'b0;
        step();
        check_eq("release accept count", 32'(alog.size()), 32'd5);
        check_eq("release pending_count", 32'(pend), 32'd4);
        enq(0, 1'b1, 1'b0, AW'(32'h505), '0, 2'b00, cyc);
        force_rdv = 1'b1; step(); step(); force_rdv = 1'b0;
        check_eq("push+pop pending_count", 32'(pend), 32'd3);

        // Asynchronous reset in the middle of a stalled write.
        force_wait = 1'b1;
        enq(0, 1'b0, 1'b1, AW'(32'h600), DW'(32'h1234), 2'b00, cyc);
        step(); step();
        drive_inputs();
        #1; rst = 1'b1; #1;
        check_eq("async rst m0_waitrequest", 32'(m0_wait), 32'd1);
        check_eq("async rst m1_waitrequest", 32'(m1_wait), 32'd1);
        check_eq("async rst chipselect", 32'(sd_cs), 32'd0);
        check_eq("async rst read_n", 32'(sd_rdn), 32'd1);
        check_eq("async rst write_n", 32'(sd_wrn), 32'd1);
        check_eq("async rst pending_count", 32'(pend), 32'd0);
        check_eq("async rst err_orphan", 32'(err), 32'd0);
        model_reset();
        @(posedge clk); #1; cyc++;
        step();
        force_wait = 1'b0; rst = 1'b0;

        // Orphan response.
        vlog.delete(); ret_mode = 2;
        force_rdv = 1'b1; step(); force_rdv = 1'b0;
        check_eq("orphan no master valid", 32'(vlog.size()), 32'd0);
        step(); step();
        check_eq("orphan sticky", 32'(err), 32'd1);
        rst = 1'b1; model_reset(); step(); rst = 1'b0;
        check_eq("orphan cleared by reset", 32'(err), 32'd0);

        // Randomized traffic.
        ret_mode = 0; rand_wait = 1'b1;
        for (int m = 0; m < 2; m++) begin
            t = cyc;
            for (int i = 0; i < 250; i++) begin
                int k;
                t += int'($urandom_range(0, 4));
                k = int'($urandom_range(0, 9));
                enq(m, (k < 4) || (k == 9), k >= 4, AW'($urandom), DW'($urandom), BW'($urandom), t);
            end
        end
        run_until_idle("random", 20000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
